// File: rtl/difftest_commit_buf_if.sv
// Writeback-to-difftest bundle for difftest_commit_buf.
// Optional skip fields exist only under DIFFTEST_CMT_SKIP_EN.
interface difftest_commit_buf_if #(
    parameter int NCOMMIT = 2,
    parameter int XLEN    = 64
);
    logic [NCOMMIT-1:0]      wb_valid;
    logic [NCOMMIT*XLEN-1:0] wb_pc;
    logic [NCOMMIT*32-1:0]   wb_inst;
    logic [NCOMMIT-1:0]      wb_rf_we;
    logic [NCOMMIT*5-1:0]    wb_rf_wnum;
    logic [NCOMMIT*XLEN-1:0] wb_rf_wdata;
    logic                    stall_o;
    logic                    cmt_ready;
    logic                    cmt_valid;
    logic [XLEN-1:0]         cmt_pc;
    logic [31:0]             cmt_inst;
    logic                    cmt_wen;
    logic [7:0]              cmt_wdest;
    logic [XLEN-1:0]         cmt_wdata;
`ifdef DIFFTEST_CMT_SKIP_EN
    logic [NCOMMIT-1:0]      wb_skip;
    logic                    cmt_skip;
`endif

    modport master (
        output wb_valid, wb_pc, wb_inst, wb_rf_we, wb_rf_wnum,
        output wb_rf_wdata, cmt_ready,
`ifdef DIFFTEST_CMT_SKIP_EN
        output wb_skip,
        input  cmt_skip,
`endif
        input  stall_o, cmt_valid, cmt_pc, cmt_inst, cmt_wen,
        input  cmt_wdest, cmt_wdata
    );

    modport slave (
        input  wb_valid, wb_pc, wb_inst, wb_rf_we, wb_rf_wnum,
        input  wb_rf_wdata, cmt_ready,
`ifdef DIFFTEST_CMT_SKIP_EN
        input  wb_skip,
        output cmt_skip,
`endif
        output stall_o, cmt_valid, cmt_pc, cmt_inst, cmt_wen,
        output cmt_wdest, cmt_wdata
    );
endinterface

// File: rtl/difftest_commit_buf.sv
// Multi-channel commit buffer: compacts up to NCOMMIT retired records per
// cycle into a DEPTH-entry FIFO and presents one commit per cycle.
// Ports: clk, rst_n (sync, active-low), bus (slave modport: wb_* in,
// stall_o out, cmt_ready in, cmt_* out), a0_i, trap, trap_code,
// cycle_cnt, instr_cnt. Optional macro DIFFTEST_CMT_SKIP_EN adds
// wb_skip / cmt_skip storage.
module difftest_commit_buf #(
    parameter int         NCOMMIT     = 2,
    parameter int         DEPTH       = 8,
    parameter int         XLEN        = 64,
    parameter logic [6:0] TRAP_OPCODE = 7'h6b
) (
    input  logic                 clk,
    input  logic                 rst_n,
    difftest_commit_buf_if.slave bus,
    input  logic [XLEN-1:0]      a0_i,
    output logic                 trap,
    output logic [7:0]           trap_code,
    output logic [63:0]          cycle_cnt,
    output logic [63:0]          instr_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(NCOMMIT + 1);

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [31:0]     mem_inst  [DEPTH];
    logic            mem_wen   [DEPTH];
    logic [4:0]      mem_wnum  [DEPTH];
    logic [XLEN-1:0] mem_wdata [DEPTH];
`ifdef DIFFTEST_CMT_SKIP_EN
    logic            mem_skip  [DEPTH];
`endif

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [7:0]    pend_code;
    logic          pend_set;

    logic          stall;
    logic          push;
    logic          cv;
    logic          pop;
    logic          head_trap;
    logic          any_trap;
    logic [OW-1:0] npush;
    logic [OW-1:0] off  [NCOMMIT];
    logic [PW-1:0] slot [NCOMMIT];
    logic [CW-1:0] add;

    logic unused_a0;
    assign unused_a0 = ^a0_i[XLEN-1:8];

    // Free space is judged on the registered count only; a pop in the
    // same cycle does not make room for this cycle's push.
    always_comb begin
        stall     = ((CW'(DEPTH) - count) < CW'(NCOMMIT)) | trap;
        push      = ~stall;
        cv        = (count != '0) & ~trap;
        pop       = cv & bus.cmt_ready;
        head_trap = (mem_inst[head][6:0] == TRAP_OPCODE);
    end

    // Running popcount gives each valid channel its compacted tail slot.
    always_comb begin
        npush    = '0;
        any_trap = 1'b0;
        for (int i = 0; i < NCOMMIT; i++) begin
            off[i]  = npush;
            slot[i] = tail + PW'(npush);
            if (bus.wb_valid[i]) begin
                npush = npush + OW'(1);
                if (bus.wb_inst[i*32 +: 7] == TRAP_OPCODE) begin
                    any_trap = 1'b1;
                end
            end
        end
        add = push ? CW'(npush) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            trap      <= 1'b0;
            trap_code <= '0;
            pend_code <= '0;
            pend_set  <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_pc[e]    <= '0;
                mem_inst[e]  <= '0;
                mem_wen[e]   <= 1'b0;
                mem_wnum[e]  <= '0;
                mem_wdata[e] <= '0;
`ifdef DIFFTEST_CMT_SKIP_EN
                mem_skip[e]  <= 1'b0;
`endif
            end
        end else begin
            if (push) begin
                for (int i = 0; i < NCOMMIT; i++) begin
                    if (bus.wb_valid[i]) begin
                        mem_pc[slot[i]]    <= bus.wb_pc[i*XLEN +: XLEN];
                        mem_inst[slot[i]]  <= bus.wb_inst[i*32 +: 32];
                        mem_wen[slot[i]]   <= bus.wb_rf_we[i] &
                            (bus.wb_rf_wnum[i*5 +: 5] != 5'd0);
                        mem_wnum[slot[i]]  <= bus.wb_rf_wnum[i*5 +: 5];
                        mem_wdata[slot[i]] <= bus.wb_rf_wdata[i*XLEN +: XLEN];
`ifdef DIFFTEST_CMT_SKIP_EN
                        mem_skip[slot[i]]  <= bus.wb_skip[i];
`endif
                    end
                end
                tail <= tail + PW'(npush);
                // First trap since reset owns the code; every channel this
                // cycle sees the same a0, so the oldest one wins trivially.
                if (any_trap && !pend_set) begin
                    pend_code <= a0_i[7:0];
                    pend_set  <= 1'b1;
                end
            end
            if (pop) begin
                head      <= head + PW'(1);
                instr_cnt <= instr_cnt + 64'd1;
                if (head_trap) begin
                    trap      <= 1'b1;
                    trap_code <= pend_code;
                end
            end
            count <= count + add - CW'(pop);
            if (!trap) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
        end
    end

    assign bus.stall_o   = stall;
    assign bus.cmt_valid = cv;
    assign bus.cmt_pc    = mem_pc[head];
    assign bus.cmt_inst  = mem_inst[head];
    assign bus.cmt_wen   = mem_wen[head];
    assign bus.cmt_wdest = {3'd0, mem_wnum[head]};
    assign bus.cmt_wdata = mem_wdata[head];
`ifdef DIFFTEST_CMT_SKIP_EN
    assign bus.cmt_skip  = mem_skip[head];
`endif

    logic [OW-1:0] unused_off;
    always_comb begin
        unused_off = '0;
        for (int i = 0; i < NCOMMIT; i++) begin
            unused_off = unused_off ^ off[i];
        end
    end
endmodule

// File: tb/tb_difftest_commit_buf.sv
// Self-checking bench for difftest_commit_buf: vector table, hand-written
// corner sequences and randomized traffic against a queue reference model.
module tb_difftest_commit_buf;
    localparam int NC = 2;
    localparam int D  = 8;
    localparam int XL = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a0 = '0;
    logic        trap;
    logic [7:0]  trap_code;
    logic [63:0] cycle_cnt;
    logic [63:0] instr_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    difftest_commit_buf_if #(.NCOMMIT(NC), .XLEN(XL)) bus ();

    difftest_commit_buf #(
        .NCOMMIT(NC), .DEPTH(D), .XLEN(XL), .TRAP_OPCODE(7'h6b)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .a0_i(a0),
        .trap(trap),
        .trap_code(trap_code),
        .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  wnum;
        logic [63:0] wdata;
        logic        skip;
    } rec_t;

    rec_t            q[$];
    bit              m_trap;
    logic [7:0]      m_code;
    logic [7:0]      m_pend;
    bit              m_pset;
    longint unsigned m_cyc;
    longint unsigned m_icnt;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour for one rising edge, using the inputs now applied.
    function void model_step();
        bit   stl;
        bit   cvm;
        bit   trap_n;
        rec_t r;
        if (!rst_n) begin
            q.delete();
            m_trap = 0;
            m_code = '0;
            m_pend = '0;
            m_pset = 0;
            m_cyc  = 0;
            m_icnt = 0;
            return;
        end
        stl    = ((D - q.size()) < NC) || m_trap;
        cvm    = (q.size() != 0) && !m_trap;
        trap_n = m_trap;
        if (cvm && bus.cmt_ready) begin
            r = q.pop_front();
            m_icnt++;
            if (r.inst[6:0] == 7'h6b) begin
                trap_n = 1;
                m_code = m_pend;
            end
        end
        if (!stl) begin
            for (int i = 0; i < NC; i++) begin
                if (bus.wb_valid[i]) begin
                    r.pc    = bus.wb_pc[i*XL +: XL];
                    r.inst  = bus.wb_inst[i*32 +: 32];
                    r.wnum  = bus.wb_rf_wnum[i*5 +: 5];
                    r.wen   = bus.wb_rf_we[i] && (r.wnum != 0);
                    r.wdata = bus.wb_rf_wdata[i*XL +: XL];
`ifdef DIFFTEST_CMT_SKIP_EN
                    r.skip  = bus.wb_skip[i];
`else
                    r.skip  = 1'b0;
`endif
                    q.push_back(r);
                    if (r.inst[6:0] == 7'h6b && !m_pset) begin
                        m_pend = a0[7:0];
                        m_pset = 1;
                    end
                end
            end
        end
        if (!m_trap) m_cyc++;
        m_trap = trap_n;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit es;
        bit ev;
        es = ((D - q.size()) < NC) || m_trap;
        ev = (q.size() != 0) && !m_trap;
        chk({tag, " stall"}, 64'(bus.stall_o), 64'(es));
        chk({tag, " cmt_valid"}, 64'(bus.cmt_valid), 64'(ev));
        chk({tag, " trap"}, 64'(trap), 64'(m_trap));
        chk({tag, " trap_code"}, 64'(trap_code), 64'(m_code));
        chk({tag, " cycle_cnt"}, cycle_cnt, m_cyc);
        chk({tag, " instr_cnt"}, instr_cnt, m_icnt);
        if (ev) begin
            chk({tag, " pc"}, bus.cmt_pc, q[0].pc);
            chk({tag, " inst"}, 64'(bus.cmt_inst), 64'(q[0].inst));
            chk({tag, " wen"}, 64'(bus.cmt_wen), 64'(q[0].wen));
            chk({tag, " wdest"}, 64'(bus.cmt_wdest), {59'd0, q[0].wnum});
            chk({tag, " wdata"}, bus.cmt_wdata, q[0].wdata);
`ifdef DIFFTEST_CMT_SKIP_EN
            chk({tag, " skip"}, 64'(bus.cmt_skip), 64'(q[0].skip));
`endif
        end
    endtask

    task automatic set_ch(input int i, input logic v, input logic [63:0] pc,
                          input logic [31:0] inst, input logic we,
                          input logic [4:0] wnum, input logic [63:0] wdata,
                          input logic skip);
        bus.wb_valid[i]            = v;
        bus.wb_pc[i*XL +: XL]      = pc;
        bus.wb_inst[i*32 +: 32]    = inst;
        bus.wb_rf_we[i]            = we;
        bus.wb_rf_wnum[i*5 +: 5]   = wnum;
        bus.wb_rf_wdata[i*XL +: XL] = wdata;
`ifdef DIFFTEST_CMT_SKIP_EN
        bus.wb_skip[i]             = skip;
`else
        if (skip) bus.wb_rf_we[i] = we;
`endif
    endtask

    function automatic logic [31:0] rinst();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 29) == 0) v[6:0] = 7'h6b;
        else if (v[6:0] == 7'h6b) v[0] = ~v[0];
        return v;
    endfunction

    task automatic drive_rand();
        for (int i = 0; i < NC; i++) begin
            set_ch(i, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                   rinst(), 1'($urandom_range(0, 1)), 5'($urandom),
                   {$urandom, $urandom}, $urandom_range(0, 3) == 0);
        end
        bus.cmt_ready = $urandom_range(0, 9) < 7;
        a0 = {$urandom, $urandom};
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NC; i++) set_ch(i, 0, '0, '0, 0, '0, '0, 0);
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [63:0] pc0;
        logic [63:0] pc1;
        logic        we;
        logic [4:0]  wnum;
        logic [63:0] wdata;
        logic        ready;
        logic        e_cv;
        logic [63:0] e_pc;
        logic        e_wen;
        logic [7:0]  e_wdest;
        logic [63:0] e_wdata;
        logic [63:0] e_icnt;
        logic        e_stall;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{2'b11, 64'h80000000, 64'h80000004, 1'b1, 5'd5, 64'h11,
                   1'b1, 1'b1, 64'h80000000, 1'b1, 8'd5, 64'h11, 64'd0, 1'b0};
        tbl[1] = '{2'b10, 64'h0000bad0, 64'h80000008, 1'b1, 5'd6, 64'h22,
                   1'b1, 1'b1, 64'h80000004, 1'b1, 8'd5, 64'h11, 64'd1, 1'b0};
        tbl[2] = '{2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0,
                   1'b1, 1'b1, 64'h80000008, 1'b1, 8'd6, 64'h22, 64'd2, 1'b0};
        tbl[3] = '{2'b01, 64'h80000100, 64'h0, 1'b1, 5'd0, 64'hdead,
                   1'b1, 1'b1, 64'h80000100, 1'b0, 8'd0, 64'hdead, 64'd3, 1'b0};
        tbl[4] = '{2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0,
                   1'b0, 1'b1, 64'h80000100, 1'b0, 8'd0, 64'hdead, 64'd3, 1'b0};
        tbl[5] = '{2'b01, 64'h80000200, 64'h0, 1'b0, 5'd7, 64'h77,
                   1'b1, 1'b1, 64'h80000200, 1'b0, 8'd7, 64'h77, 64'd4, 1'b0};
        tbl[6] = '{2'b00, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0,
                   1'b1, 1'b0, 64'h0, 1'b0, 8'd0, 64'h0, 64'd5, 1'b0};

        // Reset with random inputs, then idle count check.
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_rand();
            tick();
        end
        chk("rst cmt_valid", 64'(bus.cmt_valid), 64'd0);
        chk("rst cmt_pc", bus.cmt_pc, 64'd0);
        chk("rst cmt_inst", 64'(bus.cmt_inst), 64'd0);
        chk("rst cmt_wen", 64'(bus.cmt_wen), 64'd0);
        chk("rst cmt_wdest", 64'(bus.cmt_wdest), 64'd0);
        chk("rst cmt_wdata", bus.cmt_wdata, 64'd0);
        chk("rst stall", 64'(bus.stall_o), 64'd0);
        chk("rst trap", 64'(trap), 64'd0);
        chk("rst trap_code", 64'(trap_code), 64'd0);
        chk("rst cycle_cnt", cycle_cnt, 64'd0);
        chk("rst instr_cnt", instr_cnt, 64'd0);
        rst_n = 1'b1;
        idle_inputs();
        bus.cmt_ready = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("idle cycle_cnt", cycle_cnt, 64'd10);
        chk("idle instr_cnt", instr_cnt, 64'd0);

        // Ordering, compaction and x0 handling from the vector table.
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < NC; i++) begin
                set_ch(i, tbl[r].valid[i], (i == 0) ? tbl[r].pc0 : tbl[r].pc1,
                       32'h00000013, tbl[r].we, tbl[r].wnum, tbl[r].wdata, 0);
            end
            bus.cmt_ready = tbl[r].ready;
            tick();
            chk($sformatf("vec%0d cmt_valid", r), 64'(bus.cmt_valid),
                64'(tbl[r].e_cv));
            chk($sformatf("vec%0d stall", r), 64'(bus.stall_o),
                64'(tbl[r].e_stall));
            chk($sformatf("vec%0d instr_cnt", r), instr_cnt, tbl[r].e_icnt);
            if (tbl[r].e_cv) begin
                chk($sformatf("vec%0d pc", r), bus.cmt_pc, tbl[r].e_pc);
                chk($sformatf("vec%0d wen", r), 64'(bus.cmt_wen),
                    64'(tbl[r].e_wen));
                chk($sformatf("vec%0d wdest", r), 64'(bus.cmt_wdest),
                    64'(tbl[r].e_wdest));
                chk($sformatf("vec%0d wdata", r), bus.cmt_wdata,
                    tbl[r].e_wdata);
            end
        end

        // Back-pressure: fill to DEPTH with no consumer.
        bus.cmt_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            set_ch(0, 1, 64'h1000 + 64'(8 * p), 32'h13, 1, 5'd1, 64'(p), 0);
            set_ch(1, 1, 64'h1004 + 64'(8 * p), 32'h13, 1, 5'd2, 64'(p), 0);
            tick();
            chk($sformatf("bp fill%0d stall", p), 64'(bus.stall_o),
                64'(p == 3));
        end
        set_ch(0, 1, 64'h2000, 32'h13, 1, 5'd1, 64'h0, 0);
        set_ch(1, 1, 64'h2004, 32'h13, 1, 5'd1, 64'h0, 0);
        bus.cmt_ready = 1'b1;
        tick();
        chk("bp pop1 stall", 64'(bus.stall_o), 64'd1);
        chk("bp pop1 pc", bus.cmt_pc, 64'h1004);
        tick();
        chk("bp pop2 stall", 64'(bus.stall_o), 64'd0);
        chk("bp pop2 pc", bus.cmt_pc, 64'h1008);
        idle_inputs();
        for (int j = 2; j < 8; j++) begin
            chk($sformatf("bp drain%0d valid", j), 64'(bus.cmt_valid), 64'd1);
            chk($sformatf("bp drain%0d pc", j), bus.cmt_pc,
                64'h1000 + 64'(4 * j));
            tick();
        end
        check_model("bp end");

        // Trap behind two normal records.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.cmt_ready = 1'b0;
        a0 = 64'h11;
        set_ch(0, 1, 64'h3000, 32'h13, 1, 5'd3, 64'h1, 0);
        set_ch(1, 1, 64'h3004, 32'h13, 1, 5'd4, 64'h2, 0);
        tick();
        set_ch(0, 1, 64'h3008, 32'h0000006b, 0, 5'd0, 64'h0, 0);
        set_ch(1, 0, 64'h0, 32'h0, 0, 5'd0, 64'h0, 0);
        a0 = 64'h2A;
        tick();
        idle_inputs();
        a0 = 64'h55;
        bus.cmt_ready = 1'b1;
        tick();
        tick();
        chk("trap pre", 64'(trap), 64'd0);
        tick();
        chk("trap set", 64'(trap), 64'd1);
        chk("trap code", 64'(trap_code), 64'h2A);
        chk("trap instr_cnt", instr_cnt, 64'd3);
        chk("trap stall", 64'(bus.stall_o), 64'd1);
        chk("trap cmt_valid", 64'(bus.cmt_valid), 64'd0);
        for (int c = 0; c < 5; c++) begin
            drive_rand();
            bus.cmt_ready = 1'b1;
            tick();
        end
        check_model("trap frozen");
        chk("trap frozen instr_cnt", instr_cnt, 64'd3);
        rst_n = 1'b0;
        tick();
        chk("trap rst trap", 64'(trap), 64'd0);
        chk("trap rst code", 64'(trap_code), 64'd0);
        chk("trap rst cycle_cnt", cycle_cnt, 64'd0);
        chk("trap rst stall", 64'(bus.stall_o), 64'd0);
        rst_n = 1'b1;

`ifdef DIFFTEST_CMT_SKIP_EN
        bus.cmt_ready = 1'b0;
        set_ch(0, 1, 64'h4000, 32'h13, 1, 5'd1, 64'h1, 0);
        set_ch(1, 1, 64'h4004, 32'h13, 1, 5'd1, 64'h2, 1);
        tick();
        idle_inputs();
        chk("skip ch0", 64'(bus.cmt_skip), 64'd0);
        bus.cmt_ready = 1'b1;
        tick();
        chk("skip ch1", 64'(bus.cmt_skip), 64'd1);
        tick();
        chk("skip drained", 64'(bus.cmt_valid), 64'd0);
        chk("skip instr_cnt", instr_cnt, 64'd2);
`endif

        // Randomized traffic with occasional resets, mostly after traps.
        for (int c = 0; c < 800; c++) begin
            drive_rand();
            if (m_trap && $urandom_range(0, 5) == 0) rst_n = 1'b0;
            else if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
